// File: rtl/raw_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// raw_hazard_unit_pkg
// Shared types and constants for the RAW hazard / forwarding-control unit.
//   slot_t            : one pipeline-slot record {valid, rd, rf_wb, load}
//   RAW_*             : bit positions inside the 4-bit RAW_hazards bus
//   MW_*              : bit positions inside the 2-bit RAW_mem_wb_hazards bus
//   slot_match()      : does a slot produce the register a source reads?
// ---------------------------------------------------------------------------
package raw_hazard_unit_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rf_wb;
        logic       load;
    } slot_t;

    // RAW_hazards = {rs1_ex, rs2_ex, rs1_mem, rs2_mem}
    localparam int unsigned RAW_RS1_EX  = 3;
    localparam int unsigned RAW_RS2_EX  = 2;
    localparam int unsigned RAW_RS1_MEM = 1;
    localparam int unsigned RAW_RS2_MEM = 0;

    // RAW_mem_wb_hazards = {rs1_wb_load, rs2_wb_load}
    localparam int unsigned MW_RS1_WB_LOAD = 1;
    localparam int unsigned MW_RS2_WB_LOAD = 0;

    // x0 is hard-wired to zero, so a write to it is never a real producer.
    function automatic logic slot_match(input slot_t s, input logic [4:0] rs);
        return s.valid & s.rf_wb & (s.rd != 5'd0) & (s.rd == rs);
    endfunction

endpackage

// File: rtl/raw_hazard_unit_operand_check.sv
// ---------------------------------------------------------------------------
// raw_operand_check
// Hazard classification for a single decode source operand.
// Ports:
//   rs         in  : source register address in decode
//   ex_slot    in  : instruction currently in EX
//   mem_slot   in  : instruction currently in MEM
//   wb_slot    in  : instruction currently in WB
//   ex         out : forward from EX (ALU result)
//   mem        out : forward from MEM (ALU result)
//   wb_load    out : forward the load data returning in WB
//   load_stall out : a load in EX or MEM produces this operand
// Outputs are not gated by decode validity; the top level does that.
// ---------------------------------------------------------------------------
module raw_operand_check
    import raw_hazard_unit_pkg::*;
(
    input  logic [4:0] rs,
    input  slot_t      ex_slot,
    input  slot_t      mem_slot,
    input  slot_t      wb_slot,
    output logic       ex,
    output logic       mem,
    output logic       wb_load,
    output logic       load_stall
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // Only the youngest producer may raise a flag: an EX match shadows MEM
    // and WB even when the EX producer is a load that cannot forward yet.
    always_comb begin
        ex_hit     = slot_match(ex_slot, rs);
        mem_hit    = slot_match(mem_slot, rs);
        wb_hit     = slot_match(wb_slot, rs);

        ex         = ex_hit & ~ex_slot.load;
        mem        = ~ex_hit & mem_hit & ~mem_slot.load;
        wb_load    = ~ex_hit & ~mem_hit & wb_hit & wb_slot.load;
        load_stall = (ex_hit & ex_slot.load) | (mem_hit & mem_slot.load);
    end

endmodule

// File: rtl/raw_hazard_unit.sv
// ---------------------------------------------------------------------------
// raw_hazard_unit
// Tracks the destinations of the instructions in EX, MEM and WB and derives
// forwarding flags, the load-use stall, the redirect flush and the WB valid
// qualifier for the decode stage.
// Ports:
//   clk, rst             : core clock, asynchronous active-low reset
//   dec_valid            : decode holds a real instruction
//   rs1_dec, rs2_dec     : decode source addresses
//   rd_dec               : decode destination
//   rf_wb_dec, load_dec  : decode writes the RF / is a load
//   redirect_ex          : taken branch/jump resolved in EX
//   RAW_hazards          : {rs1_ex, rs2_ex, rs1_mem, rs2_mem}
//   RAW_mem_wb_hazards   : {rs1_wb_load, rs2_wb_load}
//   stall, flush         : hold decode / squash decode
//   we_valid             : WB slot holds a real instruction
//   stall_cnt, flush_cnt : saturating counts of stall / flush cycles
// ---------------------------------------------------------------------------
module raw_hazard_unit
    import raw_hazard_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [4:0]       rs1_dec,
    input  logic [4:0]       rs2_dec,
    input  logic [4:0]       rd_dec,
    input  logic             rf_wb_dec,
    input  logic             load_dec,
    input  logic             redirect_ex,
    output logic [3:0]       RAW_hazards,
    output logic [1:0]       RAW_mem_wb_hazards,
    output logic             stall,
    output logic             flush,
    output logic             we_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    slot_t ex_q, ex_d;
    slot_t mem_q, mem_d;
    slot_t wb_q, wb_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic rs1_ex, rs1_mem, rs1_wb_load, rs1_load_stall;
    logic rs2_ex, rs2_mem, rs2_wb_load, rs2_load_stall;

    raw_operand_check u_rs1_check (
        .rs         (rs1_dec),
        .ex_slot    (ex_q),
        .mem_slot   (mem_q),
        .wb_slot    (wb_q),
        .ex         (rs1_ex),
        .mem        (rs1_mem),
        .wb_load    (rs1_wb_load),
        .load_stall (rs1_load_stall)
    );

    raw_operand_check u_rs2_check (
        .rs         (rs2_dec),
        .ex_slot    (ex_q),
        .mem_slot   (mem_q),
        .wb_slot    (wb_q),
        .ex         (rs2_ex),
        .mem        (rs2_mem),
        .wb_load    (rs2_wb_load),
        .load_stall (rs2_load_stall)
    );

    // Combinational outputs. A redirect squashes decode anyway, so it
    // suppresses the load-use stall in the same cycle.
    always_comb begin
        RAW_hazards                        = '0;
        RAW_hazards[RAW_RS1_EX]            = dec_valid & rs1_ex;
        RAW_hazards[RAW_RS2_EX]            = dec_valid & rs2_ex;
        RAW_hazards[RAW_RS1_MEM]           = dec_valid & rs1_mem;
        RAW_hazards[RAW_RS2_MEM]           = dec_valid & rs2_mem;

        RAW_mem_wb_hazards                 = '0;
        RAW_mem_wb_hazards[MW_RS1_WB_LOAD] = dec_valid & rs1_wb_load;
        RAW_mem_wb_hazards[MW_RS2_WB_LOAD] = dec_valid & rs2_wb_load;

        flush     = redirect_ex;
        stall     = dec_valid & (rs1_load_stall | rs2_load_stall) & ~redirect_ex;
        we_valid  = wb_q.valid;
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

    // Slot advance: a stalled or flushed decode enters EX as a fully zeroed
    // bubble so stale rd values never linger in an invalid slot.
    always_comb begin
        wb_d  = mem_q;
        mem_d = ex_q;
        ex_d  = '0;
        if (dec_valid && !stall && !flush) begin
            ex_d.valid = 1'b1;
            ex_d.rd    = rd_dec;
            ex_d.rf_wb = rf_wb_dec;
            ex_d.load  = load_dec;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: doc/raw_hazard_unit.md
# raw_hazard_unit

Hazard detection and forwarding-control unit for the pipelined RV32I core. It tracks the destination register of every instruction in EX, MEM and WB. It produces the per-operand forwarding flags consumed by the decode stage, the load-use stall, the redirect flush and the writeback-valid qualifier. It sits beside the decode stage and is the producing end of the `RAW_hazards` / `RAW_mem_wb_hazards` / `we_valid` interface.

## Interface
- `CNT_W`, 32: width of the stall and flush performance counters (saturating).
- `clk` input 1: core clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `dec_valid` input 1: decode holds a real instruction (0 = bubble).
- `rs1_dec`, `rs2_dec` input 5: decode source addresses, LUI already forces rs1 = 0.
- `rd_dec` input 5: decode destination.
- `rf_wb_dec` input 1: decode instruction writes the register file.
- `load_dec` input 1: decode instruction is a load (`wb_src[1]`).
- `redirect_ex` input 1: taken branch or jump resolved in EX this cycle.
- `RAW_hazards` output 4: {rs1_ex, rs2_ex, rs1_mem, rs2_mem}.
- `RAW_mem_wb_hazards` output 2: {rs1_wb_load, rs2_wb_load}.
- `stall` output 1: hold PC and the IF/DEC register; inject a bubble into EX.
- `flush` output 1: squash IF/DEC; inject a bubble into EX.
- `we_valid` output 1: the WB slot holds a real instruction.
- `stall_cnt`, `flush_cnt` output CNT_W: cycles with stall / flush asserted.

## Operation
- The block holds three slots: EX, MEM and WB. Each slot stores {valid, rd, rf_wb, load}.
- Slot match for a source `rs`: `valid & rf_wb & rd != 0 & rd == rs`.
- Flags for a source `rs` (same rules for rs1 and rs2):
  - EX match, not a load → `*_ex` = 1.
  - Else MEM match, not a load → `*_mem` = 1.
  - Else WB match and WB is a load → `*_wb_load` = 1.
  - All flags are gated by `dec_valid`.
  - Only the youngest matching slot raises a flag. A WB load is shadowed by any EX/MEM match on the same register.
- `stall` = `dec_valid` & (EX match on a load | MEM match on a load) for either source, & `~redirect_ex`.
- When `stall` is asserted, all forwarding flags for the operand that caused it are still driven per the rules above. Decode discards them because it is held.
- `flush` = `redirect_ex`. Redirect has priority over stall.
- Slot update at the clock edge:
  - WB ← MEM, and MEM ← EX.
  - EX ← decode fields with valid = `dec_valid & ~stall & ~flush`. Otherwise EX becomes a bubble (valid = 0).
- `we_valid` = WB.valid.
- Counters increment on each asserted cycle and saturate at all-ones.

## Timing
- Reset (asynchronous assert, release synchronous to `clk`):
  - All slots go invalid, with rd = 0.
  - `stall`, `flush`, `we_valid` and all flags are 0.
  - Both counters are 0.
- All outputs are combinational from the slot state and the decode inputs. Zero-cycle latency, with no internal register between the inputs and `stall`/`flush`.
- Load-use distance 1 (load in EX, consumer in DEC): 2 stall cycles. Distance 2: 1 stall cycle. The consumer then sees `*_wb_load` = 1 in the following cycle.
- `redirect_ex` during a stall: flush wins in that cycle, the stall drops, and EX receives a bubble.
- rd = x0 never raises a flag or a stall.
- `rs1_dec == rs2_dec`: both operands raise identical flags.
- Reset asserted mid-stall: the stall ends immediately and the in-flight slots are lost.

## Structure
- Shared package holds:
  - a slot typedef {valid, rd[4:0], rf_wb, load};
  - the hazard-bus bit-position constants for `RAW_hazards` and `RAW_mem_wb_hazards`.
- Sub-module `raw_operand_check`: one source address plus three slots in; {ex, mem, wb_load, load_stall} out. It is instantiated twice, once for rs1 and once for rs2.
- Slot pipeline, stall/flush logic and counters live in the top level.

## Test plan
- ADD x5 followed by ADD x6,x5,x5 → cycle 2: `RAW_hazards` = 4'b1100, no stall.
- ADD x5, NOP, SUB x7,x5,x1 → `RAW_hazards` = 4'b0010.
- LW x5 then ADD x6,x5,x0:
  - `stall` = 1 for exactly 2 cycles and `stall_cnt` = 2;
  - then `RAW_mem_wb_hazards` = 2'b10 and `RAW_hazards` = 0.
- LW x5 in WB with ADDI x5 in MEM, consumer reads x5 → `rs1_mem` = 1 and `rs1_wb_load` = 0 (younger wins).
- LW x5 in EX, consumer in DEC, `redirect_ex` = 1 in the same cycle:
  - `flush` = 1 and `stall` = 0;
  - the next EX slot is invalid and `flush_cnt` = 1.
- ADDI x0 followed by a reader of x0 → all flags 0; after 3 cycles `we_valid` = 1 for the ADDI and 0 for the bubbles.
